// File: rtl/mem_stage_forward_unit.sv
// ---------------------------------------------------------------------------
// mem_stage_forward_unit
//   Store-data forwarding for the memory stage. A store in stage 3 reads its
//   data register (REG_READ_ADDR_S3). That register may be written by the
//   instruction now in stage 4. It may also have been written by one of the
//   last DEPTH instructions that retired out of stage 4. This unit selects
//   the freshest copy of the value.
//
//   If the stage-4 producer is a load and memory is busy, the load data is
//   not ready yet. HOLD then asks the hazard unit to stall, and a small FSM
//   times the wait. The FSM raises a sticky ERR if the wait runs past
//   TIMEOUT cycles.
//
// Ports
//   CLK, RESET          clock; asynchronous active-low reset
//   REG_READ_ADDR_S3    store-data source register (stage 3)
//   STAGE_3_MEM_WRITE   stage-3 instruction is a store
//   STAGE4_REG_ADDR     stage-4 destination register
//   STAGE_4_MEM_READ    stage-4 instruction is a load
//   STAGE4_REG_WRITE_EN stage-4 instruction writes a register
//   STAGE4_DATA         stage-4 result / load data
//   MEM_BUSY            memory not ready; pipeline frozen
//   MUX_OUT             0 none, 1 stage 4, 2 history
//   FWD_DATA            forwarded store data
//   HOLD                stall request
//   ERR                 sticky wait-timeout flag
// ---------------------------------------------------------------------------
module mem_stage_forward_unit #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] REG_READ_ADDR_S3,
    input  logic              STAGE_3_MEM_WRITE,
    input  logic [ADDR_W-1:0] STAGE4_REG_ADDR,
    input  logic              STAGE_4_MEM_READ,
    input  logic              STAGE4_REG_WRITE_EN,
    input  logic [DATA_W-1:0] STAGE4_DATA,
    input  logic              MEM_BUSY,
    output logic [1:0]        MUX_OUT,
    output logic [DATA_W-1:0] FWD_DATA,
    output logic              HOLD,
    output logic              ERR
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } hist_t;

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    hist_t             hist_q [DEPTH];
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              src_nz, s4_hit, hist_hit;
    logic [DATA_W-1:0] hist_data;

    // Retired-write history: entry 0 is newest. Frozen while memory is busy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
        end else if (!MEM_BUSY) begin
            hist_q[0].vld  <= STAGE4_REG_WRITE_EN && (STAGE4_REG_ADDR != '0);
            hist_q[0].addr <= STAGE4_REG_ADDR;
            hist_q[0].data <= STAGE4_DATA;
            for (int k = 1; k < DEPTH; k++) hist_q[k] <= hist_q[k-1];
        end
    end

    assign src_nz = (REG_READ_ADDR_S3 != '0);
    assign s4_hit = STAGE_3_MEM_WRITE && STAGE4_REG_WRITE_EN && src_nz &&
                    (REG_READ_ADDR_S3 == STAGE4_REG_ADDR);

    // Scan oldest to newest so the newest matching entry is the one kept.
    always_comb begin
        hist_hit  = 1'b0;
        hist_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist_q[k].vld && (hist_q[k].addr == REG_READ_ADDR_S3)) begin
                hist_hit  = 1'b1;
                hist_data = hist_q[k].data;
            end
        end
        hist_hit = hist_hit && STAGE_3_MEM_WRITE && src_nz;
    end

    always_comb begin
        MUX_OUT  = 2'd0;
        FWD_DATA = '0;
        if (s4_hit) begin
            MUX_OUT  = 2'd1;
            FWD_DATA = STAGE4_DATA;
        end else if (hist_hit) begin
            MUX_OUT  = 2'd2;
            FWD_DATA = hist_data;
        end
    end

    assign HOLD = s4_hit && STAGE_4_MEM_READ && MEM_BUSY;
    assign ERR  = (state_q == ERROR);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A stall that loses its stage-4 match (squash) simply ends the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (HOLD) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (!MEM_BUSY || !s4_hit)      state_d = IDLE;
                else if (cnt_q == 8'(TIMEOUT)) state_d = ERROR;
                else                           cnt_d   = cnt_q + 8'd1;
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_forward_unit.sv
// ---------------------------------------------------------------------------
// Bench for mem_stage_forward_unit (DEPTH=2, TIMEOUT=4).
//   - A vector table applied while reset is held (empty history).
//   - Hand sequences for the multi-cycle cases.
//   - A random run.
//   A reference model keeps the last DEPTH retired writes. It also tracks the
//   length of the current stall streak. A streak is a run of cycles with a
//   busy stage-4 match that began with a load. ERR is due once a streak
//   exceeds TIMEOUT cycles.
// ---------------------------------------------------------------------------
module tb_mem_stage_forward_unit;
    localparam int DP = 2;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  REG_READ_ADDR_S3, STAGE4_REG_ADDR;
    logic        STAGE_3_MEM_WRITE, STAGE_4_MEM_READ, STAGE4_REG_WRITE_EN, MEM_BUSY;
    logic [31:0] STAGE4_DATA, FWD_DATA;
    logic [1:0]  MUX_OUT;
    logic        HOLD, ERR;

    mem_stage_forward_unit #(.ADDR_W(5), .DATA_W(32), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET),
        .REG_READ_ADDR_S3(REG_READ_ADDR_S3), .STAGE_3_MEM_WRITE(STAGE_3_MEM_WRITE),
        .STAGE4_REG_ADDR(STAGE4_REG_ADDR), .STAGE_4_MEM_READ(STAGE_4_MEM_READ),
        .STAGE4_REG_WRITE_EN(STAGE4_REG_WRITE_EN), .STAGE4_DATA(STAGE4_DATA),
        .MEM_BUSY(MEM_BUSY), .MUX_OUT(MUX_OUT), .FWD_DATA(FWD_DATA),
        .HOLD(HOLD), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic        m_v [DP];
    logic [4:0]  m_a [DP];
    logic [31:0] m_d [DP];
    int          streak;
    logic        m_err;

    // last sampled outputs
    logic [1:0]  s_mux;
    logic [31:0] s_fwd;
    logic        s_hold, s_err;

    typedef struct {
        logic [4:0]  s3a;
        logic        mw;
        logic [4:0]  s4a;
        logic        mr;
        logic        we;
        logic [31:0] d;
        logic        busy;
        logic [1:0]  mux;
        logic [31:0] fwd;
        logic        hold;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] s3a, input logic mw, input logic [4:0] s4a,
                         input logic mr, input logic we, input logic [31:0] d, input logic busy);
        REG_READ_ADDR_S3    = s3a;
        STAGE_3_MEM_WRITE   = mw;
        STAGE4_REG_ADDR     = s4a;
        STAGE_4_MEM_READ    = mr;
        STAGE4_REG_WRITE_EN = we;
        STAGE4_DATA         = d;
        MEM_BUSY            = busy;
    endtask

    task automatic model_clear();
        for (int k = 0; k < DP; k++) begin
            m_v[k] = 1'b0;
            m_a[k] = '0;
            m_d[k] = '0;
        end
        streak = 0;
        m_err  = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cyc(input logic [4:0] s3a, input logic mw, input logic [4:0] s4a,
                       input logic mr, input logic we, input logic [31:0] d, input logic busy);
        logic        s4, hh, eh;
        logic [31:0] hd, ef;
        logic [1:0]  em;
        drive(s3a, mw, s4a, mr, we, d, busy);
        s4 = mw && we && (s3a == s4a) && (s3a != 5'd0);
        hh = 1'b0;
        hd = '0;
        for (int k = 0; k < DP; k++)
            if (!hh && mw && s3a != 5'd0 && m_v[k] && m_a[k] == s3a) begin
                hh = 1'b1;
                hd = m_d[k];
            end
        em = s4 ? 2'd1 : (hh ? 2'd2 : 2'd0);
        ef = s4 ? d : (hh ? hd : 32'd0);
        eh = s4 && mr && busy;
        @(negedge CLK);
        s_mux = MUX_OUT; s_fwd = FWD_DATA; s_hold = HOLD; s_err = ERR;
        chk("mux",  32'(s_mux),  32'(em));
        chk("fwd",  s_fwd,       ef);
        chk("hold", 32'(s_hold), 32'(eh));
        chk("err",  32'(s_err),  32'(m_err));
        if (s4 && busy && (streak > 0 || mr)) streak++;
        else streak = 0;
        if (streak > TO) m_err = 1'b1;
        if (!busy) begin
            for (int k = DP - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_a[k] = m_a[k-1];
                m_d[k] = m_d[k-1];
            end
            m_v[0] = we && (s4a != 5'd0);
            m_a[0] = s4a;
            m_d[0] = d;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        model_clear();
        #1;
        chk("rst_err", 32'(ERR), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5'd5,  1, 5'd5,  1, 1, 32'hDEADBEEF, 0, 2'd1, 32'hDEADBEEF, 0};
        tbl[1] = '{5'd5,  1, 5'd5,  1, 1, 32'h0000CAFE, 1, 2'd1, 32'h0000CAFE, 1};
        tbl[2] = '{5'd5,  0, 5'd5,  1, 1, 32'h0000CAFE, 1, 2'd0, 32'h0,        0};
        tbl[3] = '{5'd5,  1, 5'd5,  1, 0, 32'h0000CAFE, 1, 2'd0, 32'h0,        0};
        tbl[4] = '{5'd0,  1, 5'd0,  1, 1, 32'h000000FF, 1, 2'd0, 32'h0,        0};
        tbl[5] = '{5'd3,  1, 5'd4,  1, 1, 32'h00000012, 1, 2'd0, 32'h0,        0};
        tbl[6] = '{5'd9,  1, 5'd9,  0, 1, 32'h00000034, 1, 2'd1, 32'h00000034, 0};
        tbl[7] = '{5'd31, 1, 5'd31, 1, 1, 32'h0000ABCD, 0, 2'd1, 32'h0000ABCD, 0};

        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        chk("reset_err", 32'(ERR), 32'd0);
        // Table while reset holds the history empty: outputs follow inputs only.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].s3a, tbl[i].mw, tbl[i].s4a, tbl[i].mr, tbl[i].we, tbl[i].d, tbl[i].busy);
            #2;
            chk($sformatf("tbl%0d_mux", i),  32'(MUX_OUT), 32'(tbl[i].mux));
            chk($sformatf("tbl%0d_fwd", i),  FWD_DATA,     tbl[i].fwd);
            chk($sformatf("tbl%0d_hold", i), 32'(HOLD),    32'(tbl[i].hold));
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Load-to-store forward, no stall.
        cyc(5, 1, 5, 1, 1, 32'hDEADBEEF, 0);
        chk("ld_st_mux", 32'(s_mux), 32'd1);
        chk("ld_st_fwd", s_fwd, 32'hDEADBEEF);
        chk("ld_st_hold", 32'(s_hold), 32'd0);

        // Two retired writes to r7: the newer one is forwarded.
        cyc(0, 0, 7, 0, 1, 32'h11, 0);
        cyc(0, 0, 7, 0, 1, 32'h22, 0);
        cyc(7, 1, 2, 0, 1, 32'h33, 0);
        chk("hist_newest_mux", 32'(s_mux), 32'd2);
        chk("hist_newest_fwd", s_fwd, 32'h22);

        // Register zero is never forwarded.
        cyc(0, 1, 0, 0, 1, 32'hFF, 0);
        chk("r0_mux", 32'(s_mux), 32'd0);
        chk("r0_fwd", s_fwd, 32'd0);

        // Eviction: with DEPTH=2 the r3 entry is gone after two more writes.
        cyc(0, 0, 3, 0, 1, 32'h3, 0);
        cyc(0, 0, 4, 0, 1, 32'h4, 0);
        cyc(0, 0, 9, 0, 1, 32'h9, 0);
        cyc(3, 1, 0, 0, 0, 32'h0, 0);
        chk("evict_mux", 32'(s_mux), 32'd0);

        // Busy freezes the history; simultaneous hit and advance.
        do_reset();
        cyc(0, 0, 6, 0, 1, 32'h66, 0);
        cyc(0, 0, 8, 0, 1, 32'h88, 1);
        cyc(0, 0, 9, 0, 1, 32'h99, 1);
        cyc(6, 1, 1, 0, 0, 32'h0, 0);
        chk("frozen_fwd", s_fwd, 32'h66);
        cyc(6, 1, 6, 0, 1, 32'h77, 0);
        chk("s4_over_hist", 32'(s_mux), 32'd1);
        cyc(6, 1, 0, 0, 0, 32'h0, 0);
        chk("adv_then_hist", s_fwd, 32'h77);

        // Three-cycle stall ends normally; a new four-cycle stall stays clean.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(5, 1, 5, 1, 1, 32'hAB, 1);
            chk("stall_hold", 32'(s_hold), 32'd1);
        end
        cyc(5, 1, 5, 1, 1, 32'hAB, 0);
        chk("stall_release", 32'(s_hold), 32'd0);
        for (int i = 0; i < 4; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        cyc(5, 1, 5, 1, 1, 32'hAB, 0);
        chk("stall_noerr", 32'(s_err), 32'd0);

        // Timeout: five stalled cycles set ERR, which is sticky until reset.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        chk("to_not_yet", 32'(s_err), 32'd0);
        cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        chk("to_err", 32'(s_err), 32'd1);
        cyc(5, 1, 5, 1, 1, 32'hAB, 0);
        chk("to_sticky", 32'(s_err), 32'd1);
        chk("to_fwd_ok", 32'(s_mux), 32'd1);
        do_reset();
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        chk("to_cleared", 32'(s_err), 32'd0);

        // Reset mid-wait aborts the count.
        for (int i = 0; i < 3; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        chk("rst_abort", 32'(s_err), 32'd0);

        // Squash: the match disappears mid-wait, so the next stall starts over.
        do_reset();
        for (int i = 0; i < 2; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        for (int i = 0; i < 3; i++) cyc(5, 1, 6, 1, 1, 32'hAB, 1);
        for (int i = 0; i < 4; i++) cyc(5, 1, 5, 1, 1, 32'hAB, 1);
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        chk("squash", 32'(s_err), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cyc(5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), $urandom,
                1'($urandom_range(0, 9) < 5));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_forward_unit.md
MEM_STAGE_FORWARD_UNIT -- requirements
Module: mem_stage_forward_unit

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the forwarded-data width.
REQ-003 Parameter DEPTH, default 2, range 1..4, SHALL set the number of retired-write history entries.
REQ-004 Parameter TIMEOUT, default 15, range 1..255, SHALL set the maximum wait-for-load cycles before an error is flagged.
REQ-005 Ports SHALL be, one per line, as follows:
CLK  in  1  single clock, all state updates on rising edge
RESET  in  1  asynchronous active-low reset
REG_READ_ADDR_S3  in  ADDR_W  store-data source register of the stage-3 instruction
STAGE_3_MEM_WRITE  in  1  stage-3 instruction is a store
STAGE4_REG_ADDR  in  ADDR_W  destination register of the stage-4 instruction
STAGE_4_MEM_READ  in  1  stage-4 instruction is a load
STAGE4_REG_WRITE_EN  in  1  stage-4 instruction writes a register
STAGE4_DATA  in  DATA_W  stage-4 result (load data when STAGE_4_MEM_READ=1)
MEM_BUSY  in  1  data memory not ready; pipeline frozen this cycle
MUX_OUT  out  2  0=no forward, 1=from stage 4, 2=from history
FWD_DATA  out  DATA_W  data to drive onto the store-data path
HOLD  out  1  stall request to the hazard unit
ERR  out  1  sticky wait-timeout flag

Function
REQ-006 "Advance" SHALL mean MEM_BUSY=0 in the current cycle.
REQ-007 History SHALL be a DEPTH-entry shift register of {valid, addr, data}; entry 0 newest.
REQ-008 On each advance edge, entry 0 SHALL load {STAGE4_REG_WRITE_EN & (STAGE4_REG_ADDR!=0), STAGE4_REG_ADDR, STAGE4_DATA} and entry k SHALL load entry k-1; oldest entry discarded.
REQ-009 When MEM_BUSY=1, history SHALL hold its contents.
REQ-010 s4_hit SHALL be STAGE_3_MEM_WRITE & STAGE4_REG_WRITE_EN & (REG_READ_ADDR_S3==STAGE4_REG_ADDR) & (REG_READ_ADDR_S3!=0).
REQ-011 hist_hit SHALL be STAGE_3_MEM_WRITE & (REG_READ_ADDR_S3!=0) & any valid entry with addr==REG_READ_ADDR_S3.
REQ-012 Priority SHALL be s4_hit over hist_hit; among history hits the lowest index (newest) SHALL win.
REQ-013 MUX_OUT/FWD_DATA SHALL be combinational: s4_hit -> 1/STAGE4_DATA; else hist_hit -> 2/winning entry data; else 0/all-zero.
REQ-014 Register address 0 SHALL never produce a forward.
REQ-015 FSM states SHALL be IDLE, WAIT, ERROR.
REQ-016 IDLE->WAIT when s4_hit & STAGE_4_MEM_READ & MEM_BUSY; wait counter cleared to 1 on entry.
REQ-017 In WAIT: MEM_BUSY=0 -> IDLE; MEM_BUSY=1 and counter==TIMEOUT -> ERROR; otherwise counter increments by 1 (8-bit, no wrap reachable).
REQ-018 HOLD SHALL equal s4_hit & STAGE_4_MEM_READ & MEM_BUSY, combinational, in every state including ERROR.
REQ-019 ERROR SHALL set ERR=1 and remain until reset; forwarding per REQ-013 continues unaffected.
REQ-020 If s4_hit drops while in WAIT with MEM_BUSY=1 (squash), FSM SHALL return to IDLE next edge.
REQ-021 Simultaneous advance and hit in the same cycle SHALL forward pre-edge values; history update takes effect next cycle.

Reset
REQ-022 RESET=0 SHALL asynchronously clear all history valid bits, addr and data to 0, FSM to IDLE, counter to 0, ERR to 0.
REQ-023 During reset, with history cleared, outputs SHALL follow REQ-013/REQ-018 from the inputs only.
REQ-024 Reset asserted mid-WAIT SHALL abort the wait; ERR SHALL read 0 after release.

Verification
REQ-025 Store rs2=5, stage-4 load rd=5, data 0xDEADBEEF, MEM_BUSY=0 -> MUX_OUT=1, FWD_DATA=0xDEADBEEF, HOLD=0.
REQ-026 ALU write rd=7 data 0x11 retired, next write rd=7 data 0x22 retired, then store rs2=7 with no stage-4 match -> MUX_OUT=2, FWD_DATA=0x22.
REQ-027 Store rs2=0, stage-4 write rd=0 data 0xFF -> MUX_OUT=0, FWD_DATA=0, HOLD=0.
REQ-028 Load-store hit with MEM_BUSY=1 for 3 cycles -> HOLD=1 for 3 cycles, FSM WAIT, returns IDLE, ERR=0.
REQ-029 TIMEOUT=4, MEM_BUSY held 6 cycles on hit -> ERR=1 after fourth WAIT cycle, stays 1 after MEM_BUSY drops; RESET pulse -> ERR=0.
REQ-030 DEPTH=2: three retired writes to rd=3,4,9, then store rs2=3 -> MUX_OUT=0, because the rd=3 entry was evicted.
